aes_core_scheduler: RTL and testbench
=====================================

Name: aes_core_scheduler

Overview:
- Shares one AES_top encryption core between NUM_REQ requesters using round-robin arbitration.
- Per job: captures the requester's plaintext and key, then holds AES_en high with stable AES_data_in/AES_key_in until AES_data_out_valid.
- Returns the ciphertext to the granted requester over a valid/ready handshake, then forces an idle gap so the core's round logic restarts cleanly.
- Sits between the system-side requesters and the AES_top instance. A watchdog prevents a stalled core from hanging the bus.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 64, max cycles in RUN waiting for core valid.
- GAP, 2, cycles AES_en is held low between jobs (>=1).

Ports:
- AES_clk  in  1  single clock, rising edge.
- AES_rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending, per requester.
- req_ready  out  NUM_REQ  request accepted this cycle, per requester.
- req_data  in  NUM_REQ*128  plaintext; slice i = [128*i+:128].
- req_key  in  NUM_REQ*128  key; slice i = [128*i+:128].
- rsp_valid  out  NUM_REQ  response available to requester i.
- rsp_ready  in  NUM_REQ  requester i consumes response.
- rsp_data  out  128  ciphertext (shared bus, qualified by rsp_valid).
- rsp_err  out  1  response is a timeout error; rsp_data=0.
- core_en  out  1  drives AES_top.AES_en.
- core_data_in  out  128  drives AES_top.AES_data_in.
- core_key_in  out  128  drives AES_top.AES_key_in.
- core_data_out  in  128  from AES_top.AES_data_out.
- core_data_out_valid  in  1  from AES_top.AES_data_out_valid.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, all outputs 0, captured data/key=0, counters=0.
- States: IDLE, RUN, RESP, GAP. All outputs registered except req_ready.
- IDLE:
  - grant g = first i with req_valid[i] set, scanning from rr_ptr upward mod NUM_REQ.
  - req_ready[g]=1 combinationally; all other req_ready bits = 0.
  - On accept: latch req_data[g] and req_key[g] into core_data_in/core_key_in, latch g, then go to RUN.
  - No req_valid: stay in IDLE.
- RUN:
  - core_en=1 from the first cycle after accept.
  - core_data_in/core_key_in are held constant for the whole state.
  - run_cnt counts from 0.
  - If core_data_out_valid: rsp_data<=core_data_out, rsp_err<=0, go to RESP.
  - Else if run_cnt==TIMEOUT-1: rsp_data<=0, rsp_err<=1, go to RESP.
  - If valid and timeout fire in the same cycle, valid wins.
- RESP:
  - core_en=0 and rsp_valid[g]=1.
  - rsp_data/rsp_err stay stable until rsp_ready[g]; unbounded backpressure allowed.
  - On handshake: clear rsp_valid, rr_ptr<=(g+1) mod NUM_REQ, go to GAP.
- GAP: core_en=0 for exactly GAP cycles, then IDLE. req_ready stays 0.
- core_data_out_valid outside RUN is ignored.
- rsp_ready bits for non-granted requesters are ignored.
- Latency: accept at cycle T; core_en high at T+1; response visible one cycle after core valid.
- Reset mid-job: no response is issued and the core sees en drop immediately.

Decomposition:
- aes_ctrl_pkg: state enum {IDLE,RUN,RESP,GAP}, AES_BLK_W=128, counter width function clog2(TIMEOUT).
- One sub-module, aes_rr_arbiter: combinational round-robin grant from req_valid and rr_ptr, outputting a one-hot grant and an index.

Test Plan:
- Single job, FIPS-197 vector: requester 0, key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> core_en high from T+1 until core valid; rsp_valid[0] with rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0; then core_en low for exactly 2 cycles.
- Contention: both requesters valid at reset release, req 0 key aa2bdb40bff6a5e8caa9ba3ebc1e2acc, data 00000058000000000000000000000000 -> req 0 served first, then req 1; when both are valid again, req 1 is not granted twice in a row (round-robin alternates).
- Timeout: core stub never asserts valid -> rsp_err=1, rsp_data=0 exactly 64 cycles after core_en rise; the next job proceeds normally.
- Backpressure: hold rsp_ready[0]=0 for 20 cycles -> rsp_valid/rsp_data stable and core_en=0 throughout; no new grant issued.
- Reset mid-RUN at cycle 10 of a job -> all outputs 0 asynchronously and no rsp_valid; after release, a new request is accepted with rr_ptr=0.
- Spurious core_data_out_valid pulse in IDLE and GAP -> no rsp_valid and no state change.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and sizing helpers for the AES core scheduler.
// Imported by the scheduler top and its round-robin arbiter.
package aes_ctrl_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RESP,
        ST_GAP
    } state_t;

    // Bits needed to hold a count of 0..max_count-1, never less than one.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or above rr_ptr,
// wrapping modulo NUM_REQ.
module aes_rr_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = cnt_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [IDX_W-1:0] cand;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        // Scan from the farthest offset back to rr_ptr so the closest hit is written last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                grant_idx = cand;
                grant_any = 1'b1;
            end
        end
        if (grant_any) begin
            grant = NUM_REQ'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/aes_core_scheduler.sv
// Shares one AES_top core between NUM_REQ requesters: round-robin accept,
// run with a watchdog, return the result over valid/ready, then idle GAP cycles.
module aes_core_scheduler
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64,
    parameter int GAP     = 2
) (
    input  logic                           AES_clk,
    input  logic                           AES_rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*AES_BLK_W-1:0]   req_data,
    input  logic [NUM_REQ*AES_BLK_W-1:0]   req_key,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [AES_BLK_W-1:0]           rsp_data,
    output logic                           rsp_err,
    output logic                           core_en,
    output logic [AES_BLK_W-1:0]           core_data_in,
    output logic [AES_BLK_W-1:0]           core_key_in,
    input  logic [AES_BLK_W-1:0]           core_data_out,
    input  logic                           core_data_out_valid,
    output logic                           busy
);

    localparam int IDX_W = cnt_width(NUM_REQ);
    localparam int RUN_W = cnt_width(TIMEOUT);
    localparam int GAP_W = cnt_width(GAP);

    state_t               state, next_state;
    logic [IDX_W-1:0]     rr_ptr, gnt_idx, grant_idx;
    logic [NUM_REQ-1:0]   grant;
    logic                 grant_any;
    logic [RUN_W-1:0]     run_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 run_timeout;
    logic [AES_BLK_W-1:0] data_slot [NUM_REQ];
    logic [AES_BLK_W-1:0] key_slot  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        assign data_slot[i] = req_data[i*AES_BLK_W +: AES_BLK_W];
        assign key_slot[i]  = req_key[i*AES_BLK_W +: AES_BLK_W];
    end

    aes_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign run_timeout = (run_cnt == RUN_W'(TIMEOUT - 1));
    assign busy        = (state != ST_IDLE);

    always_comb begin
        next_state = state;
        req_ready  = '0;
        case (state)
            ST_IDLE: begin
                // Gated by reset so no requester sees an accept while the block is held.
                if (grant_any && !AES_rst) begin
                    req_ready  = grant;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_data_out_valid || run_timeout) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready[gnt_idx]) begin
                    next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(GAP - 1)) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            gnt_idx      <= '0;
            run_cnt      <= '0;
            gap_cnt      <= '0;
            core_en      <= 1'b0;
            core_data_in <= '0;
            core_key_in  <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
        end else begin
            state   <= next_state;
            core_en <= (next_state == ST_RUN);
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        gnt_idx      <= grant_idx;
                        core_data_in <= data_slot[grant_idx];
                        core_key_in  <= key_slot[grant_idx];
                        run_cnt      <= '0;
                    end
                end
                ST_RUN: begin
                    run_cnt <= run_cnt + 1'b1;
                    // A core result arriving on the timeout cycle still wins.
                    if (core_data_out_valid) begin
                        rsp_data  <= core_data_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= NUM_REQ'(1) << gnt_idx;
                    end else if (run_timeout) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= NUM_REQ'(1) << gnt_idx;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[gnt_idx]) begin
                        rsp_valid <= '0;
                        gap_cnt   <= '0;
                        rr_ptr    <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Directed bench for aes_core_scheduler: a core stub, a job-level reference model
// checked every cycle, and hand-computed expectations for the key scenarios.
module tb_aes_core_scheduler;

    localparam int NUM_REQ  = 2;
    localparam int TIMEOUT  = 64;
    localparam int GAP      = 2;
    localparam int STUB_LAT = 11;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*128-1:0]   req_data = '0;
    logic [NUM_REQ*128-1:0]   req_key = '0;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready = '1;
    logic [127:0]             rsp_data;
    logic                     rsp_err;
    logic                     core_en;
    logic [127:0]             core_data_in, core_key_in, core_data_out;
    logic                     core_data_out_valid;
    logic                     busy;

    logic                     stub_valid, stub_hang = 1'b0, spur = 1'b0;
    logic [127:0]             stub_out, spur_data = 128'hdeadbeef_00000000_cafef00d_12345678;
    int                       stub_cnt;

    int n_pass = 0, n_checks = 0;
    int order [$];

    always #5 clk = ~clk;

    aes_core_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .AES_clk             (clk),
        .AES_rst             (rst),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_data            (req_data),
        .req_key             (req_key),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_data            (rsp_data),
        .rsp_err             (rsp_err),
        .core_en             (core_en),
        .core_data_in        (core_data_in),
        .core_key_in         (core_key_in),
        .core_data_out       (core_data_out),
        .core_data_out_valid (core_data_out_valid),
        .busy                (busy)
    );

    // Stand-in cipher: the FIPS-197 vector is answered exactly, anything else gets a cheap mix.
    function automatic logic [127:0] stub_cipher(input logic [127:0] d, input logic [127:0] k);
        if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return ~(d ^ k);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        return NUM_REQ'(1) << i;
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return 0;
    endfunction

    // Core stub: answers STUB_LAT cycles into a continuous core_en run unless hung.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_cnt   <= 0;
            stub_valid <= 1'b0;
            stub_out   <= '0;
        end else begin
            stub_valid <= 1'b0;
            if (core_en) begin
                stub_cnt <= stub_cnt + 1;
                if (!stub_hang && stub_cnt == STUB_LAT - 1) begin
                    stub_valid <= 1'b1;
                    stub_out   <= stub_cipher(core_data_in, core_key_in);
                end
            end else begin
                stub_cnt <= 0;
            end
        end
    end

    assign core_data_out_valid = stub_valid | spur;
    assign core_data_out       = spur ? spur_data : stub_out;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Job-level reference: who may be granted, what the core must see, what comes back.
    int           m_ptr = 0, m_idx = 0, m_gap = 0;
    bit           m_active = 0, m_hang = 0;
    logic [127:0] m_data, m_key;

    always @(negedge clk) begin : model
        bit hs, free;
        hs = 0;
        if (rst) begin
            m_ptr = 0; m_active = 0; m_gap = 0;
        end else begin
            free = !m_active && m_gap == 0;
            if (!free) check("ready_while_busy", req_ready, '0);
            else if (req_valid != 0) check("rr_grant", req_ready, onehot(rr_pick(req_valid, m_ptr)));
            else check("ready_no_req", req_ready, '0);
            if (m_active) begin
                if (core_en) begin
                    check("core_data_in", core_data_in, m_data);
                    check("core_key_in", core_key_in, m_key);
                end
                if (rsp_valid != 0) begin
                    check("rsp_owner", rsp_valid, onehot(m_idx));
                    check("rsp_data", rsp_data, m_hang ? 128'h0 : stub_cipher(m_data, m_key));
                    check("rsp_err", rsp_err, m_hang);
                    check("en_low_in_rsp", core_en, 0);
                    hs = rsp_ready[m_idx];
                end
            end else begin
                check("en_without_job", core_en, 0);
                check("rsp_without_job", rsp_valid, '0);
            end
            if (m_gap > 0) m_gap--;
            if (hs) begin
                m_active = 0;
                m_ptr    = (m_idx + 1) % NUM_REQ;
                m_gap    = GAP;
            end else if (free && (req_valid & req_ready) != 0) begin
                m_idx    = rr_pick(req_valid & req_ready, 0);
                m_data   = req_data[m_idx*128 +: 128];
                m_key    = req_key[m_idx*128 +: 128];
                m_hang   = stub_hang;
                m_active = 1;
            end
        end
    end

    // One clock: note accepts before the edge, drop the accepted requests just after it.
    task automatic step();
        logic [NUM_REQ-1:0] acc;
        @(negedge clk);
        acc = rst ? '0 : (req_valid & req_ready);
        for (int i = 0; i < NUM_REQ; i++) if (acc[i]) order.push_back(i);
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic drain();
        bit done = 0;
        for (int n = 0; n < 500; n++) begin
            if (req_valid == 0 && !busy && rsp_valid == 0) begin done = 1; break; end
            step();
        end
        check("drain_done", done, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_core_en"}, core_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rsp_valid"}, rsp_valid, '0);
        check({tag, "_rsp_data"}, rsp_data, '0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_core_data_in"}, core_data_in, '0);
        check({tag, "_core_key_in"}, core_key_in, '0);
        check({tag, "_req_ready"}, req_ready, '0);
    endtask

    task automatic do_job(input int i, input logic [127:0] d, input logic [127:0] k,
                          input logic [127:0] exp_ct, input bit hang, input int bp, input bit spur_gap);
        int           en_cnt, g, stable;
        bit           last_cv, got;
        logic [127:0] held;
        req_data[i*128 +: 128] = d;
        req_key[i*128 +: 128]  = k;
        stub_hang = hang;
        if (bp > 0) rsp_ready[i] = 1'b0;
        req_valid[i] = 1'b1;
        #1;
        check("job_grant", req_ready, onehot(i));
        step();
        check("en_rise", core_en, 1);
        en_cnt = 0; last_cv = 0; got = 0;
        for (int n = 0; n < 200; n++) begin
            if (rsp_valid != 0) begin got = 1; break; end
            if (core_en) en_cnt++;
            last_cv = core_data_out_valid;
            step();
        end
        check("rsp_arrived", got, 1);
        check("en_cycles", en_cnt, hang ? TIMEOUT : STUB_LAT + 1);
        if (!hang) check("rsp_one_after_valid", last_cv, 1);
        check("job_rsp_valid", rsp_valid, onehot(i));
        check("job_rsp_data", rsp_data, exp_ct);
        check("job_rsp_err", rsp_err, hang);
        check("job_en_low", core_en, 0);
        if (bp > 0) begin
            held   = rsp_data;
            stable = 0;
            req_valid[(i + 1) % NUM_REQ] = 1'b1;
            repeat (bp) begin
                step();
                if (rsp_valid == onehot(i) && rsp_data == held && !core_en && req_ready == 0) stable++;
            end
            check("bp_stable_cycles", stable, bp);
            rsp_ready[i] = 1'b1;
        end
        step();
        g = 0;
        while (busy && g < 20) begin
            check("gap_en_low", core_en, 0);
            if (spur_gap && g == 0) spur = 1'b1;
            g++;
            step();
            spur = 1'b0;
        end
        check("gap_cycles", g, GAP);
        check("rsp_cleared", rsp_valid, '0);
    endtask

    initial begin
        // Reset state, with both requesters already pending.
        req_data = {128'h11111111_22222222_33333333_44444444, 128'h00000058_00000000_00000000_00000000};
        req_key  = {128'h0f0e0d0c_0b0a0908_07060504_03020100, 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc};
        req_valid = 2'b11;
        step(); step();
        check_all_zero("reset");

        // Contention at reset release: requester 0 first, then 1.
        rst = 1'b0;
        #1;
        check("contention_first", req_ready, 2'b01);
        drain();

        do_job(0, FIPS_PT, FIPS_KEY, FIPS_CT, 0, 0, 0);
        do_job(1, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677, 128'h1, 128'h0, 1, 0, 0);

        // After requester 1 was served, a tie must go to requester 0.
        stub_hang = 1'b0;
        req_valid = 2'b11;
        #1;
        check("rr_after_timeout", req_ready, 2'b01);
        drain();

        do_job(0, 128'h5555, 128'haaaa, ~(128'h5555 ^ 128'haaaa), 0, 20, 0);
        drain();

        // Stray core valid while idle.
        spur = 1'b1;
        step();
        spur = 1'b0;
        step();
        check("spur_idle_busy", busy, 0);
        check("spur_idle_rsp", rsp_valid, '0);

        do_job(0, 128'h77, 128'h99, ~(128'h77 ^ 128'h99), 0, 0, 1);

        // Reset ten cycles into a job owned by requester 1.
        req_valid[1] = 1'b1;
        #1;
        check("mid_grant", req_ready, 2'b10);
        step();
        repeat (10) step();
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        step(); step();
        rst = 1'b0;
        repeat (3) begin
            step();
            check("no_rsp_after_reset", rsp_valid, '0);
        end
        req_valid = 2'b11;
        #1;
        check("ptr_after_reset", req_ready, 2'b01);
        drain();

        check("order_len", order.size(), 12);
        for (int k = 0; k < order.size() && k < 12; k++) begin
            check($sformatf("order_%0d", k), order[k], k % 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
